// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register file write port.
// Round-robin by default; a granted requester can hold the port for up to MAX_LOCK beats.
module regfile_write_arbiter #(
  parameter int ADDR_WIDTH        = 5,
  parameter int DATA_WIDTH        = 32,
  parameter int MAX_LOCK          = 8,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  last_grant,
  output logic                  locked
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;

  logic                  wr_enable_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  last_grant_q;
  logic                  locked_q;

  logic [1:0]                 vld, lck, gnt;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] data;

  logic                  acc, sel, sel_lock, cnt_full, issue;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign vld  = {req1_valid, req0_valid};
  assign lck  = {req1_lock,  req0_lock};
  assign addr = {req1_addr,  req0_addr};
  assign data = {req1_data,  req0_data};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Grant decode: ready is combinational from valid and state, forced low in reset
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          gnt[0] = vld[0] && (!vld[1] || !rr_q);
          gnt[1] = vld[1] && (!vld[0] ||  rr_q);
        end
        LOCK0:   gnt[0] = vld[0];
        LOCK1:   gnt[1] = vld[1];
        default: gnt    = 2'b00;
      endcase
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign acc      = |gnt;
  assign sel      = gnt[1];
  assign sel_lock = lck[sel];
  assign sel_addr = addr[sel];
  assign sel_data = data[sel];
  // This accept would bring the burst count to MAX_LOCK
  assign cnt_full = (lock_cnt_q == CNT_W'(MAX_LOCK - 1));
  assign issue    = acc && !((ZERO_REG_SUPPRESS != 0) && (sel_addr == '0));

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          rr_d = ~sel;
          if (sel_lock) begin
            state_d    = sel ? LOCK1 : LOCK0;
            lock_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCK0, LOCK1: begin
        if (acc) begin
          if (!sel_lock || cnt_full) begin
            state_d    = IDLE;
            rr_d       = ~sel;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Registered write port; address/data hold unless a beat is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_enable_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_grant_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      wr_enable_q <= issue;
      if (issue) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
      if (acc) last_grant_q <= sel;
      locked_q <= (state_d != IDLE);
    end
  end

  assign wr_enable  = wr_enable_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign last_grant = last_grant_q;
  assign locked     = locked_q;

endmodule
